// File: rtl/stimulus_pattern_gen_if.sv
// Bundles the sweep control inputs and the stimulus/response outputs of the pattern generator.
interface stimulus_pattern_gen_if #(
    parameter int WIDTH = 3
);
    logic             start;
    logic [1:0]       mode;
    logic             pause;
    logic             dut_out;
    logic [WIDTH-1:0] pattern;
    logic             valid;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   ones_count;

    modport master (
        output start, mode, pause, dut_out,
        input  pattern, valid, busy, done, ones_count
    );

    modport slave (
        input  start, mode, pause, dut_out,
        output pattern, valid, busy, done, ones_count
    );
endinterface

// File: rtl/stimulus_pattern_gen.sv
// Sweeps a stimulus vector through binary/Gray/walking-one/down sequences, holds each
// vector HOLD cycles and counts how many vectors produced a high response.
//
// state | meaning
// IDLE  | after reset, pattern forced to 0, waiting for start
// RUN   | sweeping, each pattern held HOLD unpaused cycles
// DONE  | sweep finished, last pattern and ones_count held until next start
module stimulus_pattern_gen #(
    parameter int WIDTH = 3,
    parameter int HOLD  = 2
) (
    input logic               clk,
    input logic               rst_n,
    stimulus_pattern_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [1:0]       MODE_BIN_UP = 2'b00;
    localparam logic [1:0]       MODE_GRAY   = 2'b01;
    localparam logic [1:0]       MODE_WALK   = 2'b10;
    localparam logic [7:0]       HOLD_LAST   = 8'(HOLD - 1);
    localparam logic [WIDTH-1:0] WALK_LAST   = WIDTH'(WIDTH - 1);
    localparam logic [WIDTH-1:0] IDX_ONE     = WIDTH'(1);
    localparam logic [WIDTH:0]   CNT_ONE     = (WIDTH+1)'(1);

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] index_q, index_d;
    logic [7:0]       hold_q, hold_d;
    logic [WIDTH:0]   ones_q, ones_d;
    logic [WIDTH-1:0] last_index;
    logic [WIDTH-1:0] pattern_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= MODE_BIN_UP;
            index_q <= '0;
            hold_q  <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            index_q <= index_d;
            hold_q  <= hold_d;
            ones_q  <= ones_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        index_d    = index_q;
        hold_d     = hold_q;
        ones_d     = ones_q;
        last_index = (mode_q == MODE_WALK) ? WALK_LAST : '1;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    mode_d  = bus.mode;
                    index_d = '0;
                    hold_d  = '0;
                    ones_d  = '0;
                end
            end
            RUN: begin
                if (!bus.pause) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d = '0;
                        if (bus.dut_out) begin
                            ones_d = ones_q + CNT_ONE;
                        end
                        // index stops on the last vector so DONE keeps driving it
                        if (index_q == last_index) begin
                            state_d = DONE;
                        end else begin
                            index_d = index_q + IDX_ONE;
                        end
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pattern_c = '0;
        if (state_q != IDLE) begin
            case (mode_q)
                MODE_BIN_UP: pattern_c = index_q;
                MODE_GRAY:   pattern_c = index_q ^ (index_q >> 1);
                MODE_WALK:   pattern_c = IDX_ONE << index_q;
                default:     pattern_c = ~index_q;
            endcase
        end
    end

    assign bus.pattern    = pattern_c;
    assign bus.busy       = (state_q == RUN);
    assign bus.done       = (state_q == DONE);
    assign bus.valid      = (state_q == RUN) && !bus.pause;
    assign bus.ones_count = ones_q;
endmodule
